// File: rtl/pattern_detect_moore.sv
// rtl/pattern_detect_moore.sv - programmable serial bit-pattern detector, Moore output
module pattern_detect_moore #(
    parameter int                 MAX_LEN         = 8,
    parameter int                 CNT_W           = 8,
    parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = 8'b0000_1001,
    parameter int                 DEFAULT_LEN     = 5,
    parameter logic               DEFAULT_OVERLAP = 1'b1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en,
    input  logic                           A,
    input  logic                           cfg_load,
    input  logic [MAX_LEN-1:0]             cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
    input  logic                           cfg_overlap,
    input  logic                           cnt_clr,
    output logic                           B,
    output logic [CNT_W-1:0]               match_count
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic               b_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [MAX_LEN-1:0] mask;
    logic               hit;
    logic               accept;

    assign B           = b_q;
    assign match_count = cnt_q;
    assign accept      = en && !cfg_load;

    // Match is evaluated on the history as it will be after this sample shifts in.
    always_comb begin
        hist_d = {hist_q[MAX_LEN-2:0], A};
        fill_d = (fill_q == MAX_LEN_L) ? fill_q : fill_q + LEN_W'(1);
        mask   = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_q));
        end
        hit = (len_q != '0) && (fill_d >= len_q) && (((hist_d ^ pat_q) & mask) == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= DEFAULT_PATTERN;
            len_q  <= LEN_W'(DEFAULT_LEN);
            ovl_q  <= DEFAULT_OVERLAP;
            b_q    <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (cfg_load) begin
                pat_q  <= cfg_pattern;
                len_q  <= (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;
                ovl_q  <= cfg_overlap;
                fill_q <= '0;
                b_q    <= 1'b0;
            end else if (en) begin
                hist_q <= hist_d;
                // Non-overlapping: keep the bits but forget they were ever counted.
                fill_q <= (hit && !ovl_q) ? '0 : fill_d;
                b_q    <= hit;
            end

            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (accept && hit && !(&cnt_q)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_pattern_detect_moore.sv
// tb/tb_pattern_detect_moore.sv - directed self-checking bench for pattern_detect_moore
module tb_pattern_detect_moore;
    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       A;
    logic       cfg_load;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       cnt_clr;
    logic       B, B2;
    logic [7:0] match_count;
    logic [1:0] match_count2;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pattern_detect_moore #(.MAX_LEN(8), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .en(en), .A(A), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .B(B), .match_count(match_count)
    );

    pattern_detect_moore #(.MAX_LEN(8), .CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .en(en), .A(A), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cnt_clr(cnt_clr), .B(B2), .match_count(match_count2)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic drive(input logic a, input logic e, input logic ld, input logic clr);
        @(negedge clk);
        A        = a;
        en       = e;
        cfg_load = ld;
        cnt_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic a);
        drive(a, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    logic [7:0] s_def = 8'b0100_1001;
    logic [7:0] b_ovl = 8'b0000_1001;
    logic [7:0] s_a5  = 8'hA5;

    initial begin
        reset = 1'b1; en = 1'b0; A = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        #23;
        check("reset_B", B, 0);
        check("reset_cnt", match_count, 0);
        reset = 1'b0;

        // default overlapping 01001 on 0,1,0,0,1,0,0,1
        for (int i = 7; i >= 0; i--) begin
            send(s_def[i]);
            check($sformatf("ovl_B_bit%0d", 8 - i), B, b_ovl[i]);
        end
        check("ovl_cnt", match_count, 2);

        // non-overlapping
        load(8'h09, 4'd5, 1'b0);
        check("load_clears_B", B, 0);
        for (int i = 7; i >= 0; i--) begin
            send(s_def[i]);
            check($sformatf("novl_B_bit%0d", 8 - i), B, (i == 3) ? 1 : 0);
        end
        check("novl_cnt", match_count, 3);
        check("novl_cnt_sat", match_count2, 3);

        // clear, then 111 with en gaps
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_cnt", match_count, 0);
        load(8'h07, 4'd3, 1'b1);
        send(1'b1);
        send(1'b1);
        check("gap_B_bit2", B, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("gap_B_idle", B, 0);
        send(1'b1);
        check("gap_B_bit3", B, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("gap_B_hold", B, 1);
        send(1'b1);
        check("gap_B_bit4", B, 1);
        check("gap_cnt", match_count, 2);

        // length clamp 9 -> 8, full-width A5
        load(8'hA5, 4'd9, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            send(s_a5[i]);
            check($sformatf("clamp_B_bit%0d", 8 - i), B, (i == 0) ? 1 : 0);
        end
        check("clamp_cnt", match_count, 3);

        // len 0 disables
        load(8'hFF, 4'd0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            send(1'b1);
            check($sformatf("len0_B_%0d", i), B, 0);
        end
        check("len0_cnt", match_count, 3);

        // saturation on the 2-bit counter, clear wins over increment
        load(8'h01, 4'd1, 1'b1);
        send(1'b1);
        send(1'b1);
        check("sat_cnt8", match_count, 5);
        check("sat_cnt2", match_count2, 3);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        check("clr_hit_B", B, 1);
        check("clr_hit_cnt8", match_count, 0);
        check("clr_hit_cnt2", match_count2, 0);

        // async reset mid-pattern
        load(8'h09, 4'd5, 1'b1);
        send(1'b0); send(1'b1); send(1'b0); send(1'b0); send(1'b1);
        check("pre_rst_B", B, 1);
        send(1'b0); send(1'b1); send(1'b0); send(1'b0);
        check("pre_rst_cnt", match_count, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_B", B, 0);
        check("async_rst_cnt", match_count, 0);
        #1;
        reset = 1'b0;
        send(1'b1);
        check("post_rst_B", B, 0);
        check("post_rst_cnt", match_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pattern_detect_moore.md
# pattern_detect_moore

Parametrised serial bit-pattern detector with a Moore output, the successor to the fixed 5-state "01001" detector. It samples one serial bit per enabled clock and raises `B` while the most recent `cfg_len` accepted bits equal a run-time programmable pattern. It also supports an overlapping or non-overlapping mode and a saturating match counter. Reset defaults reproduce the fixed detector's behaviour: pattern 01001, overlapping.

## Interface
- `MAX_LEN`, 8: longest supported pattern in bits, at least 2.
- `CNT_W`, 8: width of the match counter.
- `DEFAULT_PATTERN`, 8'b0000_1001: pattern loaded at reset. Bit `len-1` is the first bit received.
- `DEFAULT_LEN`, 5: pattern length loaded at reset.
- `DEFAULT_OVERLAP`, 1: mode loaded at reset.

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `en`, in, 1: sample-valid. `A` is accepted only when `en`=1.
- `A`, in, 1: serial data bit.
- `cfg_load`, in, 1: synchronous load of the `cfg_*` inputs.
- `cfg_pattern`, in, MAX_LEN: new pattern. Only bits `[len-1:0]` are used.
- `cfg_len`, in, $clog2(MAX_LEN+1): new length.
- `cfg_overlap`, in, 1: 1 = overlapping matches, 0 = non-overlapping.
- `cnt_clr`, in, 1: synchronous clear of `match_count`.
- `B`, out, 1: Moore match flag, registered.
- `match_count`, out, CNT_W: number of matches, saturating.

## Operation
**State held internally**
- `hist[MAX_LEN-1:0]`: accepted bits.
- `fill`: count of valid history bits, 0..MAX_LEN, saturating.
- The configuration registers `pat`, `len`, `ovl`.
- `B`.

**Accepted sample** (`en`=1, `cfg_load`=0):
- `hist <= {hist[MAX_LEN-2:0], A}`.
- `fill` increments, saturating at MAX_LEN.
- `hit` is computed on the updated history: `hit` = (`len`≠0) and (new `fill` ≥ `len`) and (new `hist[len-1:0]` == `pat[len-1:0]`).
- `B <= hit`.
- If `hit` is true and `ovl`=0, `fill <= 0`. The history bits are retained but no longer count toward a match.
- If `hit` is true, `match_count` increments, saturating at all-ones.

**`en`=0**
- `hist`, `fill` and `B` all hold. `B` reflects the state, not a pulse.

**`cfg_load`=1**
- Takes priority over `en`.
- Loads `pat`, `len` and `ovl`. `len` is clamped to MAX_LEN when `cfg_len` > MAX_LEN.
- Clears `fill` and `B`.
- The bit on `A` in that cycle is discarded.
- `match_count` is unaffected.

**`len`=0**
- The detector is disabled: `B` stays 0 and the count does not advance.
- History still shifts.

**`cnt_clr`=1**
- `match_count <= 0`.
- This wins over a simultaneous increment.

**Equivalence with the fixed FSM**
- With `len`=5, `pat`=01001 and `ovl`=1, `B` matches the fixed FSM's state==s5 output cycle-for-cycle on any stream.
- Exception: the first 4 accepted bits after reset/load cannot match. The fixed FSM has the same constraint.

## Timing
**Reset (asynchronous)**
- `hist`=0, `fill`=0, `B`=0, `match_count`=0.
- `pat`=DEFAULT_PATTERN, `len`=DEFAULT_LEN, `ovl`=DEFAULT_OVERLAP.

**Latency**
- `B` rises on the clock edge that accepts the final pattern bit, so it is visible the cycle after that bit is presented.
- `match_count` updates on the same edge.
- `B` falls on the next accepted non-matching sample, or on `cfg_load`.

**Throughput and pipeline behaviour**
- One bit per clock. There are no stalls or backpressure.
- Back-to-back matches keep `B` high across consecutive cycles. The count increments on each one.
- Reset mid-stream takes effect immediately and asynchronously. The next accepted bit is treated as bit 1 of a fresh stream.

## Test plan
- **Default mode, overlapping match.** After reset, `en`=1, stream 0,1,0,0,1,0,0,1 → `B`=1 in the cycles following bits 5 and 8 only; `match_count`=2.
- **Non-overlapping mode.** `cfg_load` with `pat`=01001, `len`=5, `ovl`=0, then the same 8-bit stream → `B`=1 only after bit 5; `match_count`=1.
- **Reprogramming and `en` gaps.** `cfg_load` with `len`=3, `pat`=111, `ovl`=1; stream 1,1,1,1 with `en`=0 for 2 cycles between bits 2 and 3 → `B`=1 after bit 3 and bit 4, held high through any `en`=0 cycles after bit 3; `match_count`=2.
- **Length clamp, full-width match and disable.**
  - `cfg_len`=MAX_LEN+1 (e.g. 9), `pat`=8'hA5 → `len` becomes 8; the stream 1,0,1,0,0,1,0,1 matches after bit 8.
  - `cfg_len`=0 → no `B` for any stream.
- **Counter saturation and clear.** With `CNT_W`=2, 5 matches → `match_count`=3. `cnt_clr` asserted on the same edge as a match → `match_count`=0.
- **Asynchronous reset mid-pattern.** Assert `reset` after 0,1,0,0, between clock edges → `B`=0, `match_count`=0 immediately. Then bit 1 alone → no match.
